// File: rtl/conv_weight_stream_tx.sv
// Weight-port transmitter for the 3x3 dilated conv engines: streams one burst of
// KERNEL*KERNEL*CHANNEL_NUM_IN words per output channel out of a 1-cycle-latency memory.
module conv_weight_stream_tx #(
    parameter int DATA_WIDTH      = 32,
    parameter int KERNEL          = 3,
    parameter int CHANNEL_NUM_IN  = 2048,
    parameter int CHANNEL_NUM_OUT = 2048,
    parameter int ADDR_WIDTH      = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  req_next,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  valid_weight_out,
    output logic                  busy,
    output logic                  done
);
    localparam int BURST_LEN = KERNEL * KERNEL * CHANNEL_NUM_IN;
    localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int OC_W      = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
    localparam int STAGES    = 2;

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_REQ, DRAIN} state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic [OC_W-1:0]   oc;
    logic              pending;
    logic              drain_cnt;
    logic [STAGES:1]   vld_pipe;

    logic last_beat, last_oc;
    assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));
    assign last_oc   = (oc == OC_W'(CHANNEL_NUM_OUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            oc        <= '0;
            pending   <= 1'b0;
            drain_cnt <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= STREAM;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                        busy      <= 1'b1;
                        beat      <= '0;
                        oc        <= '0;
                        pending   <= 1'b0;
                    end
                end
                STREAM: begin
                    // Address runs linearly across the whole load, so it just counts reads.
                    mem_addr <= mem_addr + 1'b1;
                    if (!last_beat) begin
                        beat <= beat + 1'b1;
                        if (req_next) pending <= 1'b1;
                    end else begin
                        beat <= '0;
                        if (last_oc) begin
                            state     <= DRAIN;
                            mem_rd_en <= 1'b0;
                            pending   <= 1'b0;
                            drain_cnt <= 1'b0;
                        end else begin
                            oc <= oc + 1'b1;
                            if (pending || req_next) begin
                                pending <= 1'b0;
                            end else begin
                                state     <= WAIT_REQ;
                                mem_rd_en <= 1'b0;
                            end
                        end
                    end
                end
                WAIT_REQ: begin
                    if (req_next || pending) begin
                        state     <= STREAM;
                        mem_rd_en <= 1'b1;
                        pending   <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Two cycles let the last read reach weight_out before done.
                    if (!drain_cnt) begin
                        drain_cnt <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe   <= '0;
            weight_out <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], mem_rd_en};
            if (vld_pipe[1]) weight_out <= mem_data;
        end
    end

    assign valid_weight_out = vld_pipe[STAGES];
endmodule

// File: tb/tb_conv_weight_stream_tx.sv
// Scoreboard bench for conv_weight_stream_tx with a small 2x2-channel configuration
// and a memory model that returns addr+100.
module tb_conv_weight_stream_tx;
    localparam int DW = 32;
    localparam int AW = 26;

    logic          clk = 1'b0;
    logic          reset, start, req_next;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] weight_out;
    logic          valid_weight_out, busy, done;

    conv_weight_stream_tx #(
        .DATA_WIDTH(DW), .KERNEL(3), .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .req_next(req_next),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .weight_out(weight_out), .valid_weight_out(valid_weight_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency weight memory: data = addr + 100
    initial mem_data = '0;
    always @(posedge clk) if (mem_rd_en) mem_data <= DW'(mem_addr) + 32'd100;

    typedef struct { int val; int cyc; } exp_t;
    exp_t aq[$];
    exp_t wq[$];
    int   dq[$];

    int cyc = 0;
    int base = 0;
    int total = 0;
    int bad = 0;
    int beats_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (rel cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    task automatic at_cycle(input int n);
        while ((cyc - base) < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_burst(input int addr0, input int n_rd, input int n_val, input int cyc0);
        for (int k = 0; k < n_rd; k++) aq.push_back('{addr0 + k, cyc0 + k});
        for (int k = 0; k < n_val; k++) wq.push_back('{addr0 + 100 + k, cyc0 + 2 + k});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_wout"}, int'(weight_out), 0);
        chk({tag, "_valid"}, int'(valid_weight_out), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    // Reset asserted together with start: reset must win.
    task automatic do_reset();
        reset = 1'b1;
        start = 1'b1;
        req_next = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = cyc;
        at_cycle(1);
        chk_all_zero("reset");
        reset = 1'b0;
        start = 1'b0;
        at_cycle(3);
        chk("reset_start_busy", int'(busy), 0);
        chk("reset_start_rd", int'(mem_rd_en), 0);
    endtask

    // Monitor: every DUT output event pops and compares against the scoreboard.
    always @(negedge clk) begin
        int   rel;
        exp_t e;
        rel = cyc - base;
        if (mem_rd_en === 1'b1) begin
            if (aq.size() == 0) chk("rd_unexpected", int'(mem_addr), -1);
            else begin
                e = aq.pop_front();
                chk("rd_addr", int'(mem_addr), e.val);
                chk("rd_cycle", rel, e.cyc);
            end
        end
        if (valid_weight_out === 1'b1) begin
            beats_seen++;
            if (wq.size() == 0) chk("beat_unexpected", int'(weight_out), -1);
            else begin
                e = wq.pop_front();
                chk("beat_data", int'(weight_out), e.val);
                chk("beat_cycle", rel, e.cyc);
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) chk("done_unexpected", rel, -1);
            else chk("done_cycle", rel, dq.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        req_next = 1'b0;

        // Basic load, then second burst by request
        do_reset();
        at_cycle(10);
        push_burst(0, 18, 18, 11);
        start = 1'b1;
        at_cycle(11);
        start = 1'b0;
        at_cycle(35);
        chk("wait_busy", int'(busy), 1);
        chk("wait_done", int'(done), 0);
        chk("wait_rd", int'(mem_rd_en), 0);
        chk("wait_hold_wout", int'(weight_out), 117);
        at_cycle(40);
        push_burst(18, 18, 18, 41);
        dq.push_back(60);
        req_next = 1'b1;
        at_cycle(41);
        req_next = 1'b0;
        at_cycle(59);
        chk("busy_before_done", int'(busy), 1);
        at_cycle(60);
        chk("done_pulse", int'(done), 1);
        chk("busy_at_done", int'(busy), 0);
        at_cycle(61);
        chk("done_cleared", int'(done), 0);
        at_cycle(70);
        chk("t2_aq_empty", aq.size(), 0);
        chk("t2_wq_empty", wq.size(), 0);

        // Early request during first burst, second pulse dropped
        do_reset();
        at_cycle(10);
        push_burst(0, 18, 18, 11);
        push_burst(18, 18, 18, 29);
        dq.push_back(48);
        start = 1'b1;
        at_cycle(11);
        start = 1'b0;
        at_cycle(15);
        req_next = 1'b1;
        at_cycle(17);
        req_next = 1'b0;
        at_cycle(70);
        chk("t3_idle_busy", int'(busy), 0);
        chk("t3_aq_empty", aq.size(), 0);
        chk("t3_wq_empty", wq.size(), 0);
        chk("t3_dq_empty", dq.size(), 0);

        // Reset mid-burst, then a clean restart with ignored inputs
        do_reset();
        at_cycle(10);
        push_burst(0, 10, 8, 11);
        start = 1'b1;
        at_cycle(11);
        start = 1'b0;
        at_cycle(20);
        reset = 1'b1;
        at_cycle(21);
        chk_all_zero("midrst");
        reset = 1'b0;
        at_cycle(40);
        chk("t4_abort_aq", aq.size(), 0);
        chk("t4_abort_wq", wq.size(), 0);
        at_cycle(41);
        beats_seen = 0;
        at_cycle(42);
        req_next = 1'b1;
        at_cycle(43);
        req_next = 1'b0;
        at_cycle(45);
        push_burst(0, 18, 18, 46);
        start = 1'b1;
        at_cycle(46);
        start = 1'b0;
        at_cycle(50);
        start = 1'b1;
        at_cycle(51);
        start = 1'b0;
        at_cycle(68);
        chk("t4_wait_busy", int'(busy), 1);
        at_cycle(70);
        push_burst(18, 18, 18, 71);
        dq.push_back(90);
        req_next = 1'b1;
        at_cycle(71);
        req_next = 1'b0;
        at_cycle(100);
        chk("t4_beat_total", beats_seen, 36);
        chk("t4_aq_empty", aq.size(), 0);
        chk("t4_wq_empty", wq.size(), 0);
        chk("t4_dq_empty", dq.size(), 0);
        chk("t4_idle_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_weight_stream_tx.md
Name: conv_weight_stream_tx

Overview:
- Transmitter end of the serial weight port (valid_weight_in / weight_in) of the 3x3 dilated conv engines.
- Reads weights from a 1-cycle-latency weight memory and sends one burst of KERNEL*KERNEL*CHANNEL_NUM_IN words per output channel.
- The first burst starts on start; each later burst starts when the conv engine requests it.
- Sits between the weight memory and conv_3x3_dilation_top_new (or any wrapper that exposes its weight port).

Parameters:
- DATA_WIDTH, 32, weight word width.
- KERNEL, 3, kernel width/height.
- CHANNEL_NUM_IN, 2048, input channels per output-channel burst.
- CHANNEL_NUM_OUT, 2048, number of bursts (output channels).
- ADDR_WIDTH, 26, weight memory address width; must satisfy 2^ADDR_WIDTH >= KERNEL*KERNEL*CHANNEL_NUM_IN*CHANNEL_NUM_OUT.
- BURST_LEN, KERNEL*KERNEL*CHANNEL_NUM_IN, derived localparam, words per burst.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a full weight load. Ignored unless in IDLE.
- req_next  in  1  one-cycle pulse from the conv engine requesting the next output channel's burst.
- mem_rd_en  out  1  weight memory read strobe.
- mem_addr  out  ADDR_WIDTH  weight memory word address.
- mem_data  in  DATA_WIDTH  memory read data, valid exactly 1 cycle after mem_rd_en.
- weight_out  out  DATA_WIDTH  weight word, drives weight_in of the conv.
- valid_weight_out  out  1  qualifies weight_out, drives valid_weight_in of the conv.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse after the last word of the last burst has been emitted.

Behaviour:
- Reset: all outputs 0 (mem_rd_en, mem_addr, weight_out, valid_weight_out, busy, done); counters and the pending flag cleared; FSM goes to IDLE. Reset mid-burst aborts immediately; no further valid beats follow.
- Weight order is linear, address = oc*BURST_LEN + ci*KERNEL*KERNEL + tap, so mem_addr increments by 1 per read across the whole load. Address 0 is read first.
- FSM states: IDLE, STREAM, WAIT_REQ, DRAIN.
- IDLE -> STREAM on start. busy=1 the next cycle.
- STREAM:
  - mem_rd_en=1 on every cycle of the state, for exactly BURST_LEN consecutive cycles.
  - beat counter 0..BURST_LEN-1; on the last beat the FSM leaves STREAM.
  - If oc == CHANNEL_NUM_OUT-1, go to DRAIN; otherwise oc++ and go to WAIT_REQ, or go directly back to STREAM if req is pending.
- WAIT_REQ: mem_rd_en=0. On req_next or pending, go to STREAM next cycle and clear pending.
- DRAIN: hold 2 cycles so the read pipeline empties. On the final DRAIN cycle done=1 and busy=0; next state is IDLE.
- Output pipeline:
  - rd_en is delayed 2 flops to form valid_weight_out.
  - mem_data is registered once into weight_out.
  - valid_weight_out is therefore high 2 cycles after the matching mem_rd_en.
  - weight_out holds its last value when not valid.
- Latency: start at cycle T -> first mem_rd_en at T+1 -> first valid_weight_out at T+3. Bursts are gapless internally.
- req_next handling:
  - A pulse during STREAM or WAIT_REQ sets a single-depth pending flag.
  - A second pulse while pending is dropped.
  - Pulses in IDLE or DRAIN are ignored.
  - req_next together with the last STREAM beat counts as pending.
- start while busy is ignored.
- start in the same cycle as reset: reset wins.
- Counter wrap: the beat counter resets to 0 at each burst boundary; oc never exceeds CHANNEL_NUM_OUT-1.

Test Plan (KERNEL=3, CHANNEL_NUM_IN=2, CHANNEL_NUM_OUT=2, BURST_LEN=18; memory model returns data=addr+100):
- Basic load:
  - Stimulus: reset, start at cycle 10, no req_next.
  - Required: mem_rd_en high cycles 11-28 with addr 0..17; valid_weight_out cycles 13-30 with weight_out 100..117.
  - Then idles in WAIT_REQ with busy=1 and done=0.
- Second burst by request:
  - Stimulus: continuing from the basic load, req_next at cycle 40.
  - Required: rd_en cycles 41-58 with addr 18..35; valid cycles 43-60 with data 118..135; done=1 at cycle 60 only; busy=0 from cycle 60; FSM back to IDLE.
- Early request:
  - Stimulus: req_next at cycle 15 (during the first burst), plus a second req_next at cycle 16.
  - Required: addr 18 read at cycle 29, back-to-back with the first burst, giving 36 continuous valid beats; the second pulse is dropped (no third burst); done pulses once.
- Reset mid-burst:
  - Stimulus: reset asserted at cycle 20.
  - Required: at cycle 21 all outputs are 0 and no further valid beats appear.
  - A new start then restarts from addr 0.
- Ignored inputs:
  - Stimulus: start pulse during STREAM; req_next pulse in IDLE.
  - Required: no change in address sequence or beat count; the total number of valid beats over the load equals 36.
